// File: rtl/keccak_pkg.sv
// keccak_pkg: definitions shared by the keccak byte feeder and the core's
// byte reorder logic.
//   feeder_state_t : feeder FSM state encoding
//   WORD_BYTES     : bytes per core input word
//   WORD_BITS      : bits per core input word
//   BYTE_BITS      : bits per byte lane
//   lane_msb()     : MSB bit index of byte lane n (lane 0 = bits [63:56])
package keccak_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_SEND,
    ST_SEND_PAD,
    ST_WAIT_DIG,
    ST_DRAIN,
    ST_CLEAR
  } feeder_state_t;

  localparam int WORD_BYTES = 8;
  localparam int BYTE_BITS  = 8;
  localparam int WORD_BITS  = WORD_BYTES * BYTE_BITS;

  function automatic logic [5:0] lane_msb(input logic [2:0] lane);
    return 6'(WORD_BITS - 1 - BYTE_BITS * int'(lane));
  endfunction

endpackage

// File: rtl/keccak_digest_serializer.sv
// keccak_digest_serializer: captures the core digest on a load strobe and
// replays it MSB byte first as a valid/ready byte stream.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   load             : capture k_out and start draining
//   k_out            : digest from the core
//   d_data/d_valid   : digest byte stream out
//   d_ready          : downstream ready
//   d_last           : final digest byte
//   done             : one-cycle strobe on the last byte's handshake
module keccak_digest_serializer
  import keccak_pkg::*;
#(
  parameter int OUT_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [OUT_WIDTH-1:0] k_out,
  input  logic                 d_ready,
  output logic [7:0]           d_data,
  output logic                 d_valid,
  output logic                 d_last,
  output logic                 done
);

  localparam int NBYTES = OUT_WIDTH / BYTE_BITS;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [OUT_WIDTH-1:0] dig;
  logic [IW-1:0]        idx;
  logic                 active;
  logic                 last_byte;

  assign last_byte = (idx == IW'(NBYTES - 1));

  // The digest register shifts left one byte per handshake, so the current
  // byte is always the top lane and drains to zero once fully sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig    <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (load) begin
      dig    <= k_out;
      idx    <= '0;
      active <= 1'b1;
    end else if (active && d_ready) begin
      dig <= dig << BYTE_BITS;
      if (last_byte) begin
        idx    <= '0;
        active <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign d_data  = dig[OUT_WIDTH-1 -: 8];
  assign d_valid = active;
  assign d_last  = active & last_byte;
  assign done    = active & d_ready & last_byte;

endmodule

// File: rtl/keccak_byte_feeder.sv
// keccak_byte_feeder: packs a valid/ready message byte stream into 64-bit
// words for the keccak core, then replays the core digest as a byte stream
// and resets the core between messages.
// Optional feature: define KECCAK_FEEDER_TIMEOUT_EN to enable the digest
// watchdog (TIMEOUT_CYCLES) and the sticky err flag; otherwise err = 0.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   s_data/s_valid/s_ready/s_last : message byte stream in
//   k_reset, k_in, k_in_ready, k_is_last, k_byte_num : to the core
//   k_buffer_full, k_out, k_out_ready                : from the core
//   d_data/d_valid/d_ready/d_last : digest byte stream out
//   err                         : sticky digest timeout flag
//
// state       | meaning
// ------------+----------------------------------------------------
// ST_FILL     | accept message bytes into the word buffer
// ST_SEND     | offer the packed word to the core
// ST_SEND_PAD | offer the empty last word (length multiple of 8)
// ST_WAIT_DIG | wait for the core digest
// ST_DRAIN    | stream digest bytes out
// ST_CLEAR    | one-cycle core reset before the next message
module keccak_byte_feeder
  import keccak_pkg::*;
#(
  parameter int OUT_WIDTH      = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  output logic                 k_reset,
  output logic [63:0]          k_in,
  output logic                 k_in_ready,
  output logic                 k_is_last,
  output logic [2:0]           k_byte_num,
  input  logic                 k_buffer_full,
  input  logic [OUT_WIDTH-1:0] k_out,
  input  logic                 k_out_ready,
  output logic [7:0]           d_data,
  output logic                 d_valid,
  input  logic                 d_ready,
  output logic                 d_last,
  output logic                 err
);

  feeder_state_t state, state_next;
  logic [63:0]   word;
  logic [3:0]    cnt;
  logic          last_seen;
  logic          word_full;
  logic          partial;
  logic          dig_load;
  logic          dig_done;
  logic          timeout_hit;

  assign word_full = (cnt == 4'(WORD_BYTES));
  assign partial   = last_seen & ~word_full;

`ifdef KECCAK_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
`endif

  always_comb begin
    state_next  = state;
    s_ready     = 1'b0;
    k_in        = '0;
    k_in_ready  = 1'b0;
    k_is_last   = 1'b0;
    k_byte_num  = '0;
    dig_load    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_FILL: begin
        s_ready = 1'b1;
        if (s_valid && (s_last || cnt == 4'(WORD_BYTES - 1)))
          state_next = ST_SEND;
      end
      ST_SEND: begin
        k_in_ready = 1'b1;
        k_in       = word;
        if (partial) begin
          k_is_last  = 1'b1;
          k_byte_num = cnt[2:0];
        end
        if (!k_buffer_full) begin
          if (last_seen && word_full) state_next = ST_SEND_PAD;
          else if (partial)           state_next = ST_WAIT_DIG;
          else                        state_next = ST_FILL;
        end
      end
      ST_SEND_PAD: begin
        k_in_ready = 1'b1;
        k_is_last  = 1'b1;
        if (!k_buffer_full) state_next = ST_WAIT_DIG;
      end
      ST_WAIT_DIG: begin
        if (k_out_ready) begin
          dig_load   = 1'b1;
          state_next = ST_DRAIN;
        end
`ifdef KECCAK_FEEDER_TIMEOUT_EN
        else if (tmr == '0) begin
          timeout_hit = 1'b1;
          state_next  = ST_FILL;
        end
`endif
      end
      ST_DRAIN: begin
        if (dig_done) state_next = ST_CLEAR;
      end
      ST_CLEAR: state_next = ST_FILL;
      default:  state_next = ST_FILL;
    endcase
    k_reset = reset | (state == ST_CLEAR) | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FILL;
      word      <= '0;
      cnt       <= '0;
      last_seen <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_FILL && s_valid) begin
        // First byte of a word also clears the stale lower lanes.
        if (cnt == '0) word <= {s_data, 56'h0};
        else           word[lane_msb(cnt[2:0]) -: 8] <= s_data;
        cnt       <= cnt + 1'b1;
        last_seen <= s_last;
      end else if (state != ST_FILL && state_next == ST_FILL) begin
        cnt       <= '0;
        last_seen <= 1'b0;
      end
    end
  end

`ifdef KECCAK_FEEDER_TIMEOUT_EN
  // Down-counter loaded on entry so the terminal count lands on the
  // TIMEOUT_CYCLES-th cycle spent in ST_WAIT_DIG.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr <= '0;
      err <= 1'b0;
    end else begin
      if (state != ST_WAIT_DIG && state_next == ST_WAIT_DIG)
        tmr <= TW'(TIMEOUT_CYCLES - 1);
      else if (state == ST_WAIT_DIG && tmr != '0)
        tmr <= tmr - 1'b1;
      if (timeout_hit) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  keccak_digest_serializer #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_serializer (
    .clk     (clk),
    .reset   (reset),
    .load    (dig_load),
    .k_out   (k_out),
    .d_ready (d_ready),
    .d_data  (d_data),
    .d_valid (d_valid),
    .d_last  (d_last),
    .done    (dig_done)
  );

endmodule

// File: tb/tb_keccak_byte_feeder.sv
// Bench for keccak_byte_feeder: a stub core hashes the bytes it receives with
// a toy function, and the bench predicts words and digest bytes directly from
// the message it sends.
module tb_keccak_byte_feeder;

  localparam int OUT_WIDTH = 512;
  localparam int NB        = OUT_WIDTH / 8;
`ifdef KECCAK_FEEDER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [7:0]           s_data = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic                 s_last = 1'b0;
  logic                 k_reset;
  logic [63:0]          k_in;
  logic                 k_in_ready;
  logic                 k_is_last;
  logic [2:0]           k_byte_num;
  logic                 k_buffer_full = 1'b0;
  logic [OUT_WIDTH-1:0] k_out = '0;
  logic                 k_out_ready = 1'b0;
  logic [7:0]           d_data;
  logic                 d_valid;
  logic                 d_ready = 1'b1;
  logic                 d_last;
  logic                 err;

  keccak_byte_feeder #(.OUT_WIDTH(OUT_WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .k_reset(k_reset), .k_in(k_in), .k_in_ready(k_in_ready),
    .k_is_last(k_is_last), .k_byte_num(k_byte_num),
    .k_buffer_full(k_buffer_full), .k_out(k_out), .k_out_ready(k_out_ready),
    .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready), .d_last(d_last),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dbyte(input int unsigned h, input int i);
    return 8'((h >> (8 * (i % 4))) ^ 32'(i * 7));
  endfunction

  function automatic int unsigned hstep(input int unsigned h, input logic [7:0] b);
    return h * 31 + 32'(b) + 1;
  endfunction

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [2:0]  bn;
  } kw_t;

  kw_t         exp_words[$];
  logic [7:0]  msg[$];
  logic [7:0]  exp_dig[NB];

  // stub core state
  int unsigned core_h = 0;
  int          lat = 0;
  bit          core_mute = 0;
  bit          rand_bf = 0;
  int          bf_word = -1;
  int          bf_left = 0;
  bit          stalled = 0;
  logic [63:0] stall_word = '0;
  int          words_this_msg = 0;
  logic [63:0] first_word = '0;
  logic        first_last = 1'b0;
  logic [2:0]  first_bn = '0;
  logic [2:0]  last_bn = '0;
  bit          pad_seen = 0;

  // digest sink state
  bit rand_dready = 0;
  int dig_idx = 0;
  bit clr_pend1 = 0;
  bit clr_pend2 = 0;

  always @(negedge clk) begin : core_stub
    if (k_reset) begin
      core_h        = 0;
      lat           = 0;
      k_out_ready   = 1'b0;
      k_out         = '0;
      k_buffer_full = 1'b0;
      stalled       = 0;
    end else begin
      if (lat > 0) begin
        lat--;
        if (lat == 0 && !core_mute) begin
          k_out_ready = 1'b1;
          for (int i = 0; i < NB; i++) k_out[OUT_WIDTH-1-8*i -: 8] = dbyte(core_h, i);
        end
      end
      if (k_in_ready) begin
        if (stalled) chk("k_in_stable", k_in, stall_word);
        if (words_this_msg == bf_word && bf_left > 0) begin
          k_buffer_full = 1'b1;
          bf_left--;
        end else begin
          k_buffer_full = rand_bf && ($urandom_range(0, 3) == 0);
        end
        if (!k_buffer_full) begin
          stalled = 0;
          if (exp_words.size() == 0) begin
            chk("unexpected_word", k_in, 64'h0 - 1);
          end else begin
            kw_t e;
            e = exp_words.pop_front();
            chk("k_in", k_in, e.data);
            chk("k_is_last", 64'(k_is_last), 64'(e.last));
            chk("k_byte_num", 64'(k_byte_num), 64'(e.bn));
          end
          if (words_this_msg == 0) begin
            first_word = k_in;
            first_last = k_is_last;
            first_bn   = k_byte_num;
          end
          last_bn = k_byte_num;
          if (k_is_last && k_byte_num == 3'd0) pad_seen = 1;
          for (int j = 0; j < 8; j++)
            if (!k_is_last || j < int'(k_byte_num)) core_h = hstep(core_h, k_in[63-8*j -: 8]);
          words_this_msg++;
          if (k_is_last) lat = $urandom_range(1, 6);
        end else begin
          stalled    = 1;
          stall_word = k_in;
        end
      end else begin
        k_buffer_full = 1'b0;
        stalled       = 0;
      end
    end
  end

  always @(negedge clk) begin : sink
    if (clr_pend2) begin
      chk("s_ready_after_clear", 64'(s_ready), 64'd1);
      chk("k_reset_one_cycle", 64'(k_reset), 64'd0);
      clr_pend2 = 0;
    end
    if (clr_pend1) begin
      chk("k_reset_clear", 64'(k_reset), 64'd1);
      clr_pend1 = 0;
      clr_pend2 = 1;
    end
    d_ready = rand_dready ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (d_valid && d_ready && !reset) begin
      if (dig_idx >= NB) begin
        chk("extra_digest_byte", 64'(dig_idx), 64'(NB - 1));
      end else begin
        chk("d_data", 64'(d_data), 64'(exp_dig[dig_idx]));
        chk("d_last", 64'(d_last), 64'(dig_idx == NB - 1));
      end
      dig_idx++;
      if (dig_idx == NB) clr_pend1 = 1;
    end
  end

  // Builds expected words and digest from msg and resets per-message counters.
  task automatic prepare();
    int unsigned h;
    int len;
    len = msg.size();
    exp_words.delete();
    for (int b = 0; b < len; b += 8) begin
      kw_t w;
      int n;
      n = (len - b < 8) ? len - b : 8;
      w.data = '0;
      for (int j = 0; j < n; j++) w.data[63-8*j -: 8] = msg[b+j];
      w.last = (n < 8);
      w.bn   = (n < 8) ? 3'(n) : 3'd0;
      exp_words.push_back(w);
    end
    if (len % 8 == 0) exp_words.push_back('{data: 64'h0, last: 1'b1, bn: 3'd0});
    h = 0;
    for (int i = 0; i < len; i++) h = hstep(h, msg[i]);
    for (int i = 0; i < NB; i++) exp_dig[i] = dbyte(h, i);
    dig_idx        = 0;
    words_this_msg = 0;
    pad_seen       = 0;
  endtask

  task automatic send_bytes(input bit gaps, input int limit);
    int budget;
    for (int i = 0; i < msg.size() && i < limit; i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        while ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = msg[i];
      s_last  = (i == msg.size() - 1);
      budget  = 0;
      while (!s_ready && budget < 500) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 500) begin
        chk("s_ready_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_msg(input bit gaps);
    int budget;
    prepare();
    send_bytes(gaps, msg.size());
    budget = 0;
    while ((dig_idx < NB || clr_pend1 || clr_pend2) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 3000) chk("digest_timeout", 64'(dig_idx), 64'(NB));
    chk("words_left", 64'(exp_words.size()), 64'd0);
  endtask

  task automatic load_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  task automatic load_rand(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  typedef struct {
    int len;
    int exp_words;
    int exp_bn;
    bit exp_pad;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{len: 1,  exp_words: 1, exp_bn: 1, exp_pad: 0};
    vt[1] = '{len: 3,  exp_words: 1, exp_bn: 3, exp_pad: 0};
    vt[2] = '{len: 7,  exp_words: 1, exp_bn: 7, exp_pad: 0};
    vt[3] = '{len: 8,  exp_words: 2, exp_bn: 0, exp_pad: 1};
    vt[4] = '{len: 9,  exp_words: 2, exp_bn: 1, exp_pad: 0};
    vt[5] = '{len: 16, exp_words: 3, exp_bn: 0, exp_pad: 1};
    vt[6] = '{len: 23, exp_words: 3, exp_bn: 7, exp_pad: 0};
    vt[7] = '{len: 64, exp_words: 9, exp_bn: 0, exp_pad: 1};

    // reset state
    repeat (3) @(negedge clk);
    chk("k_reset_in_reset", 64'(k_reset), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_k_reset", 64'(k_reset), 64'd0);
    chk("rst_k_in", k_in, 64'd0);
    chk("rst_k_in_ready", 64'(k_in_ready), 64'd0);
    chk("rst_k_is_last", 64'(k_is_last), 64'd0);
    chk("rst_k_byte_num", 64'(k_byte_num), 64'd0);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_d_last", 64'(d_last), 64'd0);
    chk("rst_d_data", 64'(d_data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // "abc"
    load_abc();
    run_msg(0);
    chk("abc_word", first_word, 64'h6162630000000000);
    chk("abc_is_last", 64'(first_last), 64'd1);
    chk("abc_byte_num", 64'(first_bn), 64'd3);
    chk("abc_words", 64'(words_this_msg), 64'd1);

    // length table
    for (int t = 0; t < 8; t++) begin
      load_rand(vt[t].len);
      run_msg(t[0]);
      chk("tbl_words", 64'(words_this_msg), 64'(vt[t].exp_words));
      chk("tbl_last_bn", 64'(last_bn), 64'(vt[t].exp_bn));
      chk("tbl_pad", 64'(pad_seen), 64'(vt[t].exp_pad));
    end

    // 137 bytes, core stalls 20 cycles on word 9
    bf_word = 8;
    bf_left = 20;
    load_rand(137);
    run_msg(0);
    chk("stall_applied", 64'(bf_left), 64'd0);
    chk("b137_words", 64'(words_this_msg), 64'd18);
    chk("b137_last_bn", 64'(last_bn), 64'd1);
    bf_word = -1;

    // random d_ready, back-to-back messages
    rand_dready = 1;
    load_rand(12);
    run_msg(0);
    load_abc();
    run_msg(0);

    // reset in the middle of a 20-byte message
    rand_dready = 0;
    load_rand(20);
    prepare();
    send_bytes(0, 5);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", 64'(s_ready), 64'd1);
    chk("midrst_k_reset", 64'(k_reset), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    load_abc();
    run_msg(0);
    chk("post_rst_abc_word", first_word, 64'h6162630000000000);

    // randomized messages
    rand_bf     = 1;
    rand_dready = 1;
    for (int r = 0; r < 6; r++) begin
      load_rand($urandom_range(1, 40));
      run_msg(1);
    end
    rand_bf     = 0;
    rand_dready = 0;

`ifdef KECCAK_FEEDER_TIMEOUT_EN
    begin
      int c;
      core_mute = 1;
      load_abc();
      prepare();
      send_bytes(0, 3);
      c = 0;
      while (!k_reset && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("timeout_cycle", 64'(c), 64'd16);
      @(negedge clk);
      chk("timeout_err", 64'(err), 64'd1);
      chk("timeout_k_reset_pulse", 64'(k_reset), 64'd0);
      chk("timeout_fill", 64'(s_ready), 64'd1);
      core_mute = 0;
      load_abc();
      run_msg(0);
      chk("err_sticky", 64'(err), 64'd1);
    end
`else
    chk("err_tied_low", 64'(err), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keccak_byte_feeder.md
# keccak_byte_feeder

Byte-stream front/back end for the `keccak` hash core. Accepts a message as a valid/ready byte stream and packs it into the core's 64-bit word protocol (`in`, `in_ready`, `is_last`, `byte_num`, `buffer_full`). Captures the core's digest on `out_ready` and replays it as a valid/ready byte stream. Issues the core reset between messages. Sits between a byte-oriented host (UART/DMA bridge) and one `keccak` instance.

## Interface
- `OUT_WIDTH`, 512, digest width in bits; multiple of 8; must match the attached core.
- `TIMEOUT_CYCLES`, 1024, digest watchdog limit; used only with `KECCAK_FEEDER_TIMEOUT_EN`.

- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `s_data`  in  8  message byte.
- `s_valid` / `s_ready`  in / out  1  byte handshake; transfer when both are high.
- `s_last`  in  1  marks the final message byte; qualified by `s_valid`.
- `k_reset`  out  1  reset to the core.
- `k_in`  out  64  packed word to the core.
- `k_in_ready`, `k_is_last`  out  1  to the core.
- `k_byte_num`  out  3  to the core.
- `k_buffer_full`  in  1  from the core.
- `k_out`  in  OUT_WIDTH  digest from the core.
- `k_out_ready`  in  1  digest valid from the core (sticky until core reset).
- `d_data`  out  8  digest byte.
- `d_valid` / `d_ready`  out / in  1  digest handshake.
- `d_last`  out  1  final digest byte.
- `err`  out  1  sticky timeout flag. Tied to 0 when the macro is absent.

## Operation
- FSM states: `FILL`, `SEND`, `SEND_PAD`, `WAIT_DIG`, `DRAIN`, `CLEAR`. Reset state is `FILL`.
- `FILL`:
  - `s_ready` = 1.
  - The n-th accepted byte (n = 0..7) is written to `word[63-8n:56-8n]`, so the first byte lands in bits [63:56].
  - `cnt` increments on each accepted byte.
  - On the 8th byte, or on `s_last`, the word is frozen and the FSM goes to `SEND`. `last_seen` records `s_last`.
- `SEND`:
  - `s_ready` = 0, `k_in_ready` = 1, `k_in` = word.
  - The word is accepted by the core in the cycle where `k_in_ready` is high and `k_buffer_full` is low.
  - A partial word (`s_last` with `cnt` < 8) is sent with `k_is_last` = 1 and `k_byte_num` = `cnt` (1..7). Unused low bytes are 0.
  - A full word is sent with `k_is_last` = 0 and `k_byte_num` = 0.
  - After acceptance:
    - full word and `last_seen` → `SEND_PAD`;
    - partial word → `WAIT_DIG`;
    - otherwise → `FILL` with `cnt` cleared.
- `SEND_PAD`: sends `k_in` = 0, `k_is_last` = 1, `k_byte_num` = 0 under the same acceptance rule, then goes to `WAIT_DIG`. This covers messages whose length is a multiple of 8.
- `WAIT_DIG`: on the first cycle with `k_out_ready` = 1, latch `k_out` into the digest register, clear the byte index, and go to `DRAIN`.
- `DRAIN`:
  - `d_valid` = 1.
  - `d_data` = `dig[OUT_WIDTH-1-8i : OUT_WIDTH-8-8i]`.
  - `d_last` = 1 when i = OUT_WIDTH/8 − 1.
  - The index advances on each `d_ready` handshake. The handshake on the last byte goes to `CLEAR`.
- `CLEAR`: drives `k_reset` = 1 for exactly one cycle, then goes to `FILL`.
- `k_reset` = `reset` OR (state == `CLEAR`) OR the timeout pulse.
- Outside the states above:
  - `k_in_ready`, `k_is_last` = 0;
  - `s_ready` = 0;
  - `d_valid` = 0.
- Minimum message length is 1 byte. Zero-length messages are not supported.

## Timing
- Reset values:
  - `s_ready` = 1 on the first cycle after reset;
  - `k_reset` = 1 during reset;
  - `k_in` = 0; `k_in_ready`, `k_is_last` = 0; `k_byte_num` = 0;
  - `d_valid`, `d_last` = 0; `d_data` = 0;
  - `err` = 0.
- All outputs are registered or decoded directly from state. There is no combinational path from `k_buffer_full` to `s_ready`.
- Ingest: 1 byte/cycle in `FILL`. Each word costs at least 1 extra cycle in `SEND`, longer while `k_buffer_full` = 1. `k_in`, `k_is_last` and `k_byte_num` are held stable until accepted.
- Digest: `d_valid` rises 1 cycle after `k_out_ready` is sampled high. Full drain takes OUT_WIDTH/8 cycles with `d_ready` held high.
- `CLEAR` to `s_ready` = 1 takes 1 cycle.
- `reset` asserted mid-message or mid-drain: all state is discarded, the next cycle is `FILL`, and the core is reset through `k_reset`.
- `k_out_ready` high outside `WAIT_DIG` is ignored.

## Configuration
- `KECCAK_FEEDER_TIMEOUT_EN` defined:
  - a counter runs in `WAIT_DIG`;
  - on reaching `TIMEOUT_CYCLES` without `k_out_ready`, set `err` (sticky until `reset`), pulse `k_reset` for 1 cycle, and go to `FILL`;
  - `err` is cleared only by `reset`.
- Undefined: no counter; `WAIT_DIG` waits indefinitely; `err` = 0.

## Structure
- Shared package `keccak_pkg`:
  - FSM state encoding;
  - `WORD_BYTES` = 8;
  - the byte-lane helper constants, shared with the core's byte reorder.
- One natural sub-module: `keccak_digest_serializer` (digest register, byte index, `d_*` handshake), started by a load strobe and returning a done strobe.

## Test plan
- "abc" (3 bytes, `s_last` on byte 3) → one word `k_in` = 0x6162630000000000 with `k_is_last` = 1 and `k_byte_num` = 3; 64 digest bytes equal the golden model's; `d_last` on byte 64.
- 8-byte message → one word with `k_is_last` = 0, then a pad word with `k_in` = 0, `k_is_last` = 1, `k_byte_num` = 0; digest matches the model.
- 137-byte message with `k_buffer_full` forced high for 20 cycles on word 9 → `k_in` held stable; no byte lost; final word has `k_byte_num` = 1.
- `d_ready` toggled randomly during drain → exactly 64 bytes in order; `k_reset` pulses 1 cycle after the last one; a second message hashes correctly.
- `reset` asserted at byte 5 of a 20-byte message → next cycle `s_ready` = 1 and `k_reset` = 1; a fresh "abc" then gives the correct digest.
- With the macro and `TIMEOUT_CYCLES` = 16, core stubbed to never assert `k_out_ready` → `err` = 1 at cycle 16 of `WAIT_DIG`, one `k_reset` pulse, FSM back in `FILL`.
